ship_life_sequencer: RTL and testbench

Game-flow controller that sequences the player ship through start, play, explosion, respawn and game-over phases. It drives the die/bonus inputs of the lives counter and consumes its lives/game_over outputs. Sits between the collision detector, score keeper and lives counter. Gates ship drawing/control for the video and ship-motion blocks.

---
 rtl/ship_life_pkg.sv | 40 ++++
 rtl/ship_life_sequencer_frame_timer.sv | 43 ++++
 rtl/ship_life_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ship_life_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ship_life_pkg.sv
// Shared types and constants for the ship life sequencer.
//   ship_state_t   : game-flow phases of the player ship
//   DEF_*_FRAMES   : default phase lengths in video frames
//   frame_cnt_w()  : frame counter width able to count to the longest phase
package ship_life_pkg;

    typedef enum logic [2:0] {
        ATTRACT      = 3'd0,
        INVULN       = 3'd1,
        PLAYING      = 3'd2,
        EXPLODING    = 3'd3,
        RESPAWN_WAIT = 3'd4,
        GAME_OVER    = 3'd5
    } ship_state_t;

    localparam int unsigned DEF_EXPLODE_FRAMES  = 60;
    localparam int unsigned DEF_RESPAWN_FRAMES  = 30;
    localparam int unsigned DEF_INVULN_FRAMES   = 120;
    localparam int unsigned DEF_GAMEOVER_FRAMES = 300;
    // Frames that must elapse on the game-over screen before start may skip it
    localparam int unsigned GAMEOVER_MIN_FRAMES = 60;
    localparam int unsigned FRAME_CNT_MIN_W     = 9;

    function automatic int unsigned max_frames(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int unsigned frame_cnt_w(input int unsigned longest);
        int unsigned w;
        w = $clog2(longest);
        return (w > FRAME_CNT_MIN_W) ? w : FRAME_CNT_MIN_W;
    endfunction

endpackage

// File: rtl/ship_life_sequencer_frame_timer.sv
// frame_timer: counts frame ticks since the last clear.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count at zero (wins over tick)
//   tick       : one-cycle frame pulse
//   limit      : phase length N in frames
//   count      : ticks seen since the last clear
//   done_c     : combinational, high on the tick where count == N-1
module frame_timer #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign done_c = tick && (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/ship_life_sequencer.sv
// ship_life_sequencer: game-flow controller for the player ship.
//   clk, reset      : clock, synchronous active-high reset
//   frame_tick      : one pulse per video frame
//   start           : raw start button level
//   collision       : ship-hit level from the collision detector
//   score           : current score
//   lives/game_over : state of the lives counter
//   die/bonus       : single-cycle pulses to the lives counter
//   new_game        : single-cycle pulse that reloads the lives counter
//   ship_visible, ship_enable, invulnerable, explode, show_game_over : phase flags
// All outputs are registered.
module ship_life_sequencer
    import ship_life_pkg::*;
#(
    parameter  int unsigned MAX_NUM_LIVES   = 8,
    parameter  int unsigned SCORE_W         = 17,
    parameter  int unsigned BONUS_STEP      = 10000,
    parameter  int unsigned EXPLODE_FRAMES  = DEF_EXPLODE_FRAMES,
    parameter  int unsigned RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
    parameter  int unsigned INVULN_FRAMES   = DEF_INVULN_FRAMES,
    parameter  int unsigned GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
    localparam int unsigned LIVES_W         = $clog2(MAX_NUM_LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score,
    input  logic [LIVES_W-1:0] lives,
    input  logic               game_over,
    output logic               die,
    output logic               bonus,
    output logic               new_game,
    output logic               ship_visible,
    output logic               ship_enable,
    output logic               invulnerable,
    output logic               explode,
    output logic               show_game_over
);

    localparam int unsigned CNT_W = frame_cnt_w(max_frames(EXPLODE_FRAMES, RESPAWN_FRAMES,
                                                           INVULN_FRAMES, GAMEOVER_FRAMES));
    localparam int unsigned SUM_W = SCORE_W + 1;

    ship_state_t        state_q, state_d;
    logic               start_q;
    logic [SCORE_W-1:0] next_bonus_q, next_bonus_d;
    logic               bonus_pending_q, bonus_pending_d;
    logic               die_q, die_d;
    logic               bonus_q, bonus_d;
    logic               new_game_q, new_game_d;
    logic               ship_visible_q, ship_visible_d;
    logic               ship_enable_q, ship_enable_d;
    logic               invulnerable_q, invulnerable_d;
    logic               explode_q, explode_d;
    logic               show_game_over_q, show_game_over_d;

    logic               start_rise_c;
    logic               over_c;
    logic               timer_clear_c;
    logic               timer_done_c;
    logic [CNT_W-1:0]   timer_count;
    logic [CNT_W-1:0]   frame_limit_c;
    logic               bonus_active_c;
    logic               bonus_elig_c;
    logic [SUM_W-1:0]   bonus_sum_c;

    assign start_rise_c  = start && !start_q;
    // Either indication of an empty lives counter ends the game
    assign over_c        = game_over || (lives == '0);
    assign timer_clear_c = (state_d != state_q);

    // Phase length handed to the shared frame timer
    always_comb begin
        frame_limit_c = '0;
        case (state_q)
            INVULN:       frame_limit_c = CNT_W'(INVULN_FRAMES);
            EXPLODING:    frame_limit_c = CNT_W'(EXPLODE_FRAMES);
            RESPAWN_WAIT: frame_limit_c = CNT_W'(RESPAWN_FRAMES);
            GAME_OVER:    frame_limit_c = CNT_W'(GAMEOVER_FRAMES);
            default:      frame_limit_c = '0;
        endcase
    end

    frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_c),
        .tick   (frame_tick),
        .limit  (frame_limit_c),
        .count  (timer_count),
        .done_c (timer_done_c)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ATTRACT:      if (start_rise_c) state_d = INVULN;
            INVULN:       if (timer_done_c) state_d = PLAYING;
            PLAYING:      if (collision) state_d = EXPLODING;
            EXPLODING:    if (timer_done_c) state_d = over_c ? GAME_OVER : RESPAWN_WAIT;
            RESPAWN_WAIT: if (timer_done_c) state_d = INVULN;
            GAME_OVER: begin
                if (timer_done_c ||
                    (start_rise_c && (timer_count >= CNT_W'(GAMEOVER_MIN_FRAMES)))) begin
                    state_d = ATTRACT;
                end
            end
            default:      state_d = ATTRACT;
        endcase
    end

    // Phase flags follow the state being entered so they line up with state_q
    always_comb begin
        die_d            = (state_q == PLAYING) && collision;
        new_game_d       = (state_q == ATTRACT) && start_rise_c;
        ship_visible_d   = (state_d == INVULN) || (state_d == PLAYING);
        ship_enable_d    = (state_d == INVULN) || (state_d == PLAYING);
        invulnerable_d   = (state_d == INVULN);
        explode_d        = (state_d == EXPLODING);
        show_game_over_d = (state_d == GAME_OVER);
    end

    assign bonus_active_c = (state_q != ATTRACT) && (state_q != GAME_OVER);
    assign bonus_sum_c    = {1'b0, next_bonus_q} + SUM_W'(BONUS_STEP);
    // All-ones threshold marks a saturated (exhausted) bonus schedule
    assign bonus_elig_c   = bonus_active_c && !(&next_bonus_q) && (score >= next_bonus_q);

    // Bonus award: at most one threshold is banked while a pulse is outstanding,
    // so a multi-threshold jump drains at one pulse every other cycle.
    always_comb begin
        next_bonus_d    = next_bonus_q;
        bonus_pending_d = bonus_pending_q;
        bonus_d         = 1'b0;
        if (new_game_d) begin
            next_bonus_d    = SCORE_W'(BONUS_STEP);
            bonus_pending_d = 1'b0;
        end else if (bonus_active_c) begin
            bonus_d = (bonus_pending_q || bonus_elig_c) && !die_d && !bonus_q;
            if (bonus_elig_c && (!bonus_pending_q || bonus_d)) begin
                next_bonus_d    = bonus_sum_c[SCORE_W] ? '1 : bonus_sum_c[SCORE_W-1:0];
                bonus_pending_d = bonus_pending_q || !bonus_d;
            end else begin
                bonus_pending_d = bonus_pending_q && !bonus_d;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ATTRACT;
            start_q          <= 1'b0;
            next_bonus_q     <= SCORE_W'(BONUS_STEP);
            bonus_pending_q  <= 1'b0;
            die_q            <= 1'b0;
            bonus_q          <= 1'b0;
            new_game_q       <= 1'b0;
            ship_visible_q   <= 1'b0;
            ship_enable_q    <= 1'b0;
            invulnerable_q   <= 1'b0;
            explode_q        <= 1'b0;
            show_game_over_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            start_q          <= start;
            next_bonus_q     <= next_bonus_d;
            bonus_pending_q  <= bonus_pending_d;
            die_q            <= die_d;
            bonus_q          <= bonus_d;
            new_game_q       <= new_game_d;
            ship_visible_q   <= ship_visible_d;
            ship_enable_q    <= ship_enable_d;
            invulnerable_q   <= invulnerable_d;
            explode_q        <= explode_d;
            show_game_over_q <= show_game_over_d;
        end
    end

    assign die            = die_q;
    assign bonus          = bonus_q;
    assign new_game       = new_game_q;
    assign ship_visible   = ship_visible_q;
    assign ship_enable    = ship_enable_q;
    assign invulnerable   = invulnerable_q;
    assign explode        = explode_q;
    assign show_game_over = show_game_over_q;

endmodule

// File: tb/tb_ship_life_sequencer.sv
// Scoreboard bench: the driver applies inputs at the falling edge, steps a
// phase-level reference model and queues the expected outputs; the monitor
// samples the DUT just after each rising edge and compares.
module tb_ship_life_sequencer;

    localparam int unsigned SCORE_W   = 17;
    localparam int unsigned LIVES_W   = 4;
    localparam int          STEP      = 10000;
    localparam int          EXP_F     = 60;
    localparam int          RSP_F     = 30;
    localparam int          INV_F     = 120;
    localparam int          GO_F      = 300;
    localparam int          GO_MIN    = 60;
    localparam int          MAXL      = 8;
    localparam int          SCORE_MAX = (1 << SCORE_W) - 1;

    typedef enum int {PH_ATTRACT, PH_INVULN, PH_PLAY, PH_EXPLODE, PH_RESPAWN, PH_OVER} phase_t;

    typedef struct packed {
        logic die;
        logic bonus;
        logic new_game;
        logic vis;
        logic en;
        logic inv;
        logic expl;
        logic sgo;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_tick = 1'b0;
    logic               start = 1'b0;
    logic               collision = 1'b0;
    logic               game_over = 1'b1;
    logic [SCORE_W-1:0] score = '0;
    logic [LIVES_W-1:0] lives = '0;
    logic die, bonus, new_game, ship_visible, ship_enable, invulnerable, explode, show_game_over;

    ship_life_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start          (start),
        .collision      (collision),
        .score          (score),
        .lives          (lives),
        .game_over      (game_over),
        .die            (die),
        .bonus          (bonus),
        .new_game       (new_game),
        .ship_visible   (ship_visible),
        .ship_enable    (ship_enable),
        .invulnerable   (invulnerable),
        .explode        (explode),
        .show_game_over (show_game_over)
    );

    always #5 clk = ~clk;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     timeouts = 0;
    bit     drv_done = 1'b0;

    // Reference model state (phase, frames left in phase, bonus schedule)
    phase_t m_ph = PH_ATTRACT;
    int     m_left = 0;
    int     m_nb = STEP;
    bit     m_sat = 1'b0;
    int     m_owed = 0;
    bit     m_sprev = 1'b0;
    bit     m_bprev = 1'b0;

    // Lives counter environment
    int     env_lives = 0;
    int     start_lives = 3;
    int     r_score = 0;
    bit     r_start = 1'b0;
    bit     r_col = 1'b0;

    function automatic int phase_len(input phase_t p);
        case (p)
            PH_INVULN:  return INV_F;
            PH_EXPLODE: return EXP_F;
            PH_RESPAWN: return RSP_F;
            PH_OVER:    return GO_F;
            default:    return 0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit tk, input bit st, input bit col,
                              input int sc, input bit gov);
        exp_t   e;
        bit     rise;
        bit     act;
        phase_t nxt;
        e = '0;
        if (rst) begin
            m_ph = PH_ATTRACT; m_left = 0; m_nb = STEP; m_sat = 1'b0;
            m_owed = 0; m_sprev = 1'b0; m_bprev = 1'b0;
            exp_q.push_back(e);
            return;
        end
        rise    = st && !m_sprev;
        m_sprev = st;
        act     = (m_ph != PH_ATTRACT) && (m_ph != PH_OVER);
        nxt     = m_ph;
        case (m_ph)
            PH_ATTRACT: if (rise) begin nxt = PH_INVULN; e.new_game = 1'b1; end
            PH_INVULN:  if (tk && m_left == 1) nxt = PH_PLAY;
            PH_PLAY:    if (col) begin nxt = PH_EXPLODE; e.die = 1'b1; end
            PH_EXPLODE: if (tk && m_left == 1) nxt = gov ? PH_OVER : PH_RESPAWN;
            PH_RESPAWN: if (tk && m_left == 1) nxt = PH_INVULN;
            PH_OVER:    if ((tk && m_left == 1) || (rise && (GO_F - m_left) >= GO_MIN)) nxt = PH_ATTRACT;
            default:    nxt = PH_ATTRACT;
        endcase
        if (act) begin
            if (sc >= m_nb && !m_sat) begin
                m_owed++;
                if (m_nb + STEP > SCORE_MAX) begin m_nb = SCORE_MAX; m_sat = 1'b1; end
                else m_nb += STEP;
            end
            if (m_owed > 0 && !e.die && !m_bprev) begin
                e.bonus = 1'b1;
                m_owed--;
            end
        end
        if (e.new_game) begin m_nb = STEP; m_sat = 1'b0; m_owed = 0; end
        m_bprev = e.bonus;
        if (nxt != m_ph) begin
            m_ph   = nxt;
            m_left = phase_len(nxt);
        end else if (tk) begin
            m_left--;
        end
        e.vis  = (m_ph == PH_INVULN) || (m_ph == PH_PLAY);
        e.en   = (m_ph == PH_INVULN) || (m_ph == PH_PLAY);
        e.inv  = (m_ph == PH_INVULN);
        e.expl = (m_ph == PH_EXPLODE);
        e.sgo  = (m_ph == PH_OVER);
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus
    task automatic cyc(input bit rst, input bit tk, input bit st, input bit col, input int sc);
        @(negedge clk);
        if (new_game === 1'b1) env_lives = start_lives;
        else if (die === 1'b1) begin if (env_lives > 0) env_lives--; end
        else if (bonus === 1'b1 && env_lives < MAXL) env_lives++;
        reset      = rst;
        frame_tick = tk;
        start      = st;
        collision  = col;
        score      = SCORE_W'(sc);
        lives      = LIVES_W'(env_lives);
        game_over  = (env_lives == 0);
        model_step(rst, tk, st, col, sc, (env_lives == 0));
    endtask

    task automatic run_until(input phase_t p, input int budget);
        int n;
        n = 0;
        while (m_ph != p && n < budget) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, r_score);
            n++;
        end
        if (m_ph != p) timeouts++;
    endtask

    // Driver
    initial begin : driver
        start_lives = 3;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Held start produces a single new game
        repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
        // Invulnerable phase with collisions that must be ignored
        for (int i = 0; i < 130; i++) cyc(1'b0, 1'b1, 1'b0, (i >= 20 && i < 60), 0);
        run_until(PH_PLAY, 50);
        // Multi-threshold score jump, then the next threshold at 40000
        r_score = 9990;  repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        r_score = 30010; repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        r_score = 39999; repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        r_score = 40000; repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        r_score = 49990; repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        // Threshold crossed on the collision cycle, collision held 500 cycles
        r_score = 50000;
        for (int i = 0; i < 500; i++) cyc(1'b0, (i % 4) == 0, 1'b0, 1'b1, r_score);
        run_until(PH_PLAY, 400);
        // Last life lost: explosion then game-over screen
        env_lives = 1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, r_score);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        run_until(PH_OVER, 200);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, r_score);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, r_score);
        repeat (61) cyc(1'b0, 1'b1, 1'b0, 1'b0, r_score);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, r_score);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, r_score);
        // Second game ends through the full game-over timeout
        r_score = 0; start_lives = 1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, r_score);
        run_until(PH_PLAY, 200);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, r_score);
        run_until(PH_OVER, 200);
        run_until(PH_ATTRACT, 400);
        // Bonus schedule saturation, then a mid-game reset
        r_score = 0; start_lives = 2;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, r_score);
        run_until(PH_PLAY, 200);
        r_score = SCORE_MAX;
        repeat (40) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, r_score);
        r_score = 0; r_start = 1'b0; r_col = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, r_score);
        // Randomized play
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 29) == 0) r_start = !r_start;
            if ($urandom_range(0, 39) == 0) r_col = !r_col;
            if (m_ph == PH_ATTRACT) begin
                r_score = 0;
            end else begin
                r_score += int'($urandom_range(0, 60));
                if ($urandom_range(0, 199) == 0) r_score += int'($urandom_range(10000, 35000));
                if (r_score > SCORE_MAX) r_score = SCORE_MAX;
            end
            start_lives = int'($urandom_range(1, 3));
            cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 1) == 1, r_start, r_col, r_score);
        end
        drv_done = 1'b1;
    end

    // Monitor
    initial begin : monitor
        exp_t e;
        exp_t a;
        int   n_cyc;
        int   dut_dies;
        int   exp_dies;
        int   dut_bonus;
        int   exp_bonus;
        n_cyc = 0; dut_dies = 0; exp_dies = 0; dut_bonus = 0; exp_bonus = 0;
        while (!(drv_done && exp_q.size() == 0) && n_cyc < 80000) begin
            @(posedge clk);
            #2;
            n_cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {die, bonus, new_game, ship_visible, ship_enable, invulnerable, explode, show_game_over};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got=%b expected=%b (die bonus new_game vis en inv expl sgo)",
                             $time, a, e);
                end
                if (die === 1'b1) dut_dies++;
                if (bonus === 1'b1) dut_bonus++;
                if (e.die) exp_dies++;
                if (e.bonus) exp_bonus++;
            end
        end
        checks++;
        if (n_cyc >= 80000) begin
            errors++;
            $display("FAIL watchdog: got %0d cycles, required fewer than 80000", n_cyc);
        end
        checks++;
        if (timeouts != 0) begin
            errors++;
            $display("FAIL phase_wait: got %0d expired waits, required 0", timeouts);
        end
        checks++;
        if (dut_dies != exp_dies) begin
            errors++;
            $display("FAIL die_total: got %0d required %0d", dut_dies, exp_dies);
        end
        checks++;
        if (dut_bonus != exp_bonus) begin
            errors++;
            $display("FAIL bonus_total: got %0d required %0d", dut_bonus, exp_bonus);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
